// File: rtl/mc_seq_pkg.sv
// Shared types and constants for the multi-cycle op sequencer.
package mc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    localparam logic UNIT_DIV = 1'b0;
    localparam logic UNIT_FPU = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/mc_seq_watchdog.sv
// RUN-state watchdog: 8-bit cycle counter cleared on entry to RUN.
// Only instantiated when MC_OP_SEQUENCER_TIMEOUT_EN is defined.
module mc_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    // Compare against limit-1 so the flag rises during the last allowed RUN cycle.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;

    // Clear on RUN entry, count every RUN cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i & (cnt_q == LIMIT);

endmodule

// File: rtl/mc_op_sequencer.sv
// Execute-stage sequencer for multi-cycle units (divider, FPU).
// Optional watchdog: define MC_OP_SEQUENCER_TIMEOUT_EN.
module mc_op_sequencer
    import mc_seq_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TAG_W          = 6,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             issue_valid_i,
    input  logic             issue_unit_i,
    input  logic [TAG_W-1:0] issue_tag_i,
    input  logic             hazard_i,
    input  logic             flush_i,
    input  logic             result_ack_i,
    output logic             div_start_o,
    output logic             fpu_start_o,
    output logic             abort_o,
    input  logic             div_done_i,
    input  logic [XLEN-1:0]  div_result_i,
    input  logic             fpu_done_i,
    input  logic [XLEN-1:0]  fpu_result_i,
    output logic             busy_o,
    output logic             result_valid_o,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] result_tag_o,
    output logic [31:0]      stall_cycles_o,
    output logic             error_o
);

    mc_state_e        state_q, state_d;
    logic             unit_q, unit_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             div_start_q, div_start_d;
    logic             fpu_start_q, fpu_start_d;
    logic             abort_q, abort_d;
    logic [31:0]      stall_q, stall_d;

    logic             issue_fire;
    logic             unit_done;
    logic [XLEN-1:0]  unit_result;
    logic             timeout_hit;

    assign issue_fire  = (state_q == ST_IDLE) & issue_valid_i & ~hazard_i & ~flush_i;
    assign unit_done   = (unit_q == UNIT_FPU) ? fpu_done_i   : div_done_i;
    assign unit_result = (unit_q == UNIT_FPU) ? fpu_result_i : div_result_i;

`ifdef MC_OP_SEQUENCER_TIMEOUT_EN
    logic error_q;
    logic timeout_take;

    mc_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (issue_fire),
        .run_i     (state_q == ST_RUN),
        .expired_o (timeout_hit)
    );

    // Flush and a real done both take priority over the watchdog.
    assign timeout_take = (state_q == ST_RUN) & ~flush_i & ~unit_done & timeout_hit;

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            error_q <= 1'b0;
        end else if (timeout_take) begin
            error_q <= 1'b1;
        end
    end

    assign error_o = error_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign timeout_hit    = 1'b0;
    assign error_o        = 1'b0;
`endif

    // Stall request; reset forces it low so nothing is counted while held.
    assign busy_o = ~reset_i & (((state_q == ST_IDLE) & issue_valid_i & ~flush_i) |
                                (state_q == ST_RUN));

    // Next-state, capture and pulse generation.
    always_comb begin
        state_d     = state_q;
        unit_d      = unit_q;
        tag_d       = tag_q;
        result_d    = result_q;
        div_start_d = 1'b0;
        fpu_start_d = 1'b0;
        abort_d     = 1'b0;
        stall_d     = stall_q + {31'd0, busy_o};
        unique case (state_q)
            ST_IDLE: begin
                if (issue_fire) begin
                    state_d     = ST_RUN;
                    unit_d      = issue_unit_i;
                    tag_d       = issue_tag_i;
                    div_start_d = (issue_unit_i == UNIT_DIV);
                    fpu_start_d = (issue_unit_i == UNIT_FPU);
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_d  = ST_IDLE;
                    abort_d  = 1'b1;
                    unit_d   = UNIT_DIV;
                    tag_d    = '0;
                    result_d = '0;
                end else if (unit_done) begin
                    state_d  = ST_DONE;
                    result_d = unit_result;
                end else if (timeout_hit) begin
                    state_d  = ST_DONE;
                    abort_d  = 1'b1;
                    result_d = '0;
                end
            end
            ST_DONE: begin
                if (flush_i) begin
                    state_d  = ST_IDLE;
                    unit_d   = UNIT_DIV;
                    tag_d    = '0;
                    result_d = '0;
                end else if (result_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and capture registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            unit_q      <= UNIT_DIV;
            tag_q       <= '0;
            result_q    <= '0;
            div_start_q <= 1'b0;
            fpu_start_q <= 1'b0;
            abort_q     <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            unit_q      <= unit_d;
            tag_q       <= tag_d;
            result_q    <= result_d;
            div_start_q <= div_start_d;
            fpu_start_q <= fpu_start_d;
            abort_q     <= abort_d;
            stall_q     <= stall_d;
        end
    end

    assign div_start_o    = div_start_q;
    assign fpu_start_o    = fpu_start_q;
    assign abort_o        = abort_q;
    assign result_valid_o = (state_q == ST_DONE);
    assign result_o       = result_q;
    assign result_tag_o   = tag_q;
    assign stall_cycles_o = stall_q;

endmodule
